// File: rtl/pixel_receiver.sv
// Input front-end of the 3x3 convolution engine: loads the kernel, primes two
// line buffers with zeros, then streams the image into a sliding 3x3 window.
module pixel_receiver #(
   parameter int LINE_W     = 10,
   parameter int NUM_ROWS   = 9,
   parameter int NUM_KERNEL = 9
) (
   input  logic        Phi1,
   input  logic        Reset_b_s1,
   input  logic [7:0]  Pixel_s1,
   input  logic        Out_Stall_s1,
   output logic        Input_Ready_s1,
   output logic [71:0] Kernel_s1,
   output logic [71:0] Window_s1,
   output logic        Window_Valid_s1,
   output logic [1:0]  State_s1,
   output logic        Done_s1
);
   localparam int PRIME_CNT = 2 * LINE_W;
   localparam int IMG_CNT   = LINE_W * NUM_ROWS;
   localparam int CNT_MAX   = (PRIME_CNT > IMG_CNT) ? PRIME_CNT : IMG_CNT;
   localparam int CW        = $clog2(CNT_MAX + 1);
   localparam int COLW      = $clog2(LINE_W);
   localparam int ROWW      = $clog2(NUM_ROWS + 1);

   typedef enum logic [1:0] {
      RESET       = 2'b00,
      LOAD_KERNEL = 2'b01,
      PRIME       = 2'b10,
      STREAM      = 2'b11
   } state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic                capture, ready_nxt, done_nxt;
   logic [COLW-1:0]     col;
   logic [ROWW-1:0]     row;
   logic [7:0]          lb1 [LINE_W];
   logic [7:0]          lb2 [LINE_W];
   logic [8:0][7:0]     win;

   assign State_s1  = state;
   assign Window_s1 = win;

   always_ff @(posedge Phi1) begin
      if (!Reset_b_s1) begin
         state          <= RESET;
         cnt            <= '0;
         Input_Ready_s1 <= 1'b0;
         Done_s1        <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         Input_Ready_s1 <= ready_nxt;
         Done_s1        <= done_nxt;
      end
   end

   // The first byte after reset is taken without a request; afterwards a
   // capture happens exactly one cycle after each registered request.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      done_nxt  = Done_s1;
      ready_nxt = 1'b0;
      case (state)
         RESET: begin
            capture   = 1'b1;
            cnt_nxt   = CW'(1);
            state_nxt = LOAD_KERNEL;
         end
         LOAD_KERNEL: begin
            capture = Input_Ready_s1;
            if (capture) begin
               if (cnt == CW'(NUM_KERNEL - 1)) begin
                  cnt_nxt   = '0;
                  state_nxt = PRIME;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         PRIME: begin
            capture = Input_Ready_s1;
            if (capture) begin
               if (cnt == CW'(PRIME_CNT - 1)) begin
                  cnt_nxt   = '0;
                  state_nxt = STREAM;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         STREAM: begin
            capture = Input_Ready_s1;
            if (capture) cnt_nxt = cnt + 1'b1;
            done_nxt = Done_s1 || (cnt_nxt == CW'(IMG_CNT));
         end
         default: ;
      endcase
      // Each request resolves on the following edge, so nothing is in flight
      // when the next request is decided.
      if (state_nxt == LOAD_KERNEL || state_nxt == PRIME)
         ready_nxt = 1'b1;
      else if (state_nxt == STREAM)
         ready_nxt = !Out_Stall_s1 && !done_nxt && (cnt_nxt < CW'(IMG_CNT));
   end

   always_ff @(posedge Phi1) begin
      if (!Reset_b_s1) begin
         Kernel_s1       <= '0;
         win             <= '0;
         col             <= '0;
         row             <= '0;
         Window_Valid_s1 <= 1'b0;
         for (int i = 0; i < LINE_W; i++) begin
            lb1[i] <= '0;
            lb2[i] <= '0;
         end
      end else begin
         Window_Valid_s1 <= 1'b0;
         if (capture) begin
            case (state)
               RESET, LOAD_KERNEL: Kernel_s1 <= {Kernel_s1[63:0], Pixel_s1};
               PRIME, STREAM: begin
                  for (int i = LINE_W - 1; i > 0; i--) begin
                     lb1[i] <= lb1[i-1];
                     lb2[i] <= lb2[i-1];
                  end
                  lb1[0] <= Pixel_s1;
                  lb2[0] <= lb1[LINE_W-1];
                  if (state == PRIME) begin
                     col <= '0;
                     row <= '0;
                  end else begin
                     win[2] <= win[1];
                     win[1] <= win[0];
                     win[0] <= Pixel_s1;
                     win[5] <= win[4];
                     win[4] <= win[3];
                     win[3] <= lb1[LINE_W-1];
                     win[8] <= win[7];
                     win[7] <= win[6];
                     win[6] <= lb2[LINE_W-1];
                     // Left-edge windows straddle two rows and are never flagged.
                     Window_Valid_s1 <= (col >= COLW'(2)) && (row < ROWW'(NUM_ROWS));
                     if (col == COLW'(LINE_W - 1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                     end else begin
                        col <= col + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pixel_receiver.sv
// Scoreboard bench for pixel_receiver: default build plus a LINE_W=4,
// NUM_ROWS=3 build, both fed from byte queues answering Input_Ready_s1.
module tb_pixel_receiver;
   logic Phi1 = 1'b0;
   always #5 Phi1 = ~Phi1;

   logic        Reset_b_s1, Out_Stall_s1, Input_Ready_s1, Window_Valid_s1, Done_s1;
   logic [7:0]  Pixel_s1;
   logic [71:0] Kernel_s1, Window_s1;
   logic [1:0]  State_s1;

   pixel_receiver dut (
      .Phi1(Phi1), .Reset_b_s1(Reset_b_s1), .Pixel_s1(Pixel_s1),
      .Out_Stall_s1(Out_Stall_s1), .Input_Ready_s1(Input_Ready_s1),
      .Kernel_s1(Kernel_s1), .Window_s1(Window_s1),
      .Window_Valid_s1(Window_Valid_s1), .State_s1(State_s1), .Done_s1(Done_s1)
   );

   logic        rst_b_s, stall_s, ready_s, wv_s, done_s;
   logic [7:0]  pix_s;
   logic [71:0] kern_s, win_s;
   logic [1:0]  state_s;

   pixel_receiver #(.LINE_W(4), .NUM_ROWS(3)) dut_s (
      .Phi1(Phi1), .Reset_b_s1(rst_b_s), .Pixel_s1(pix_s),
      .Out_Stall_s1(stall_s), .Input_Ready_s1(ready_s),
      .Kernel_s1(kern_s), .Window_s1(win_s),
      .Window_Valid_s1(wv_s), .State_s1(state_s), .Done_s1(done_s)
   );

   int n_chk = 0, n_fail = 0;
   int n_strobe = 0, n_strobe_s = 0;
   logic [71:0] exp_q[$], exp_qs[$];
   logic [7:0]  src[$], srcs[$];
   int ptr = 0, ptr_s = 0;
   bit small_done = 0;
   localparam int IMG_BASE = 29;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event did not occur within its cycle budget", name);
   endtask

   // Window for ramp pixel k of an L-wide image: rows above the image read 0.
   function automatic logic [71:0] exp_win(input int k, input int L);
      logic [71:0] w;
      int r, c;
      w = '0;
      r = k / L;
      c = k % L;
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < 3; i++)
            if (r - j >= 0) w[(3*j+i)*8 +: 8] = 8'((r - j) * L + c - i);
      return w;
   endfunction

   task automatic build_src(input bit ones);
      src.delete();
      for (int i = 0; i < 9; i++) src.push_back(ones ? 8'hFF : 8'(i + 1));
      for (int i = 0; i < 20; i++) src.push_back(8'h00);
      for (int i = 0; i < 90; i++) src.push_back(8'(i));
      ptr = 0;
   endtask

   // One cycle of the default-build source: present the next byte whenever
   // the DUT will capture on the coming edge.
   task automatic step(input bit rst_b, input bit stall, input bit first);
      @(negedge Phi1);
      Reset_b_s1   = rst_b;
      Out_Stall_s1 = stall;
      if (rst_b && (first || Input_Ready_s1) && ptr < src.size()) begin
         Pixel_s1 = src[ptr];
         if (ptr >= IMG_BASE && ((ptr - IMG_BASE) % 10) >= 2)
            exp_q.push_back(exp_win(ptr - IMG_BASE, 10));
         ptr++;
      end else begin
         Pixel_s1 = 8'hEE;
      end
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < 400 && ptr < target; i++) step(1'b1, 1'b0, 1'b0);
      if (ptr < target) fail_now($sformatf("reach_ptr_%0d", target));
   endtask

   task automatic load_kernel(input logic [71:0] kexp, input string tag);
      step(1'b1, 1'b0, 1'b1);
      run_to(9);
      step(1'b1, 1'b0, 1'b0);
      check({tag, "_state_prime"}, 72'(State_s1), 72'(2'b10));
      check({tag, "_kernel"}, Kernel_s1, kexp);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_ready"}, 72'(Input_Ready_s1), 72'(0));
      check({tag, "_valid"}, 72'(Window_Valid_s1), 72'(0));
      check({tag, "_done"}, 72'(Done_s1), 72'(0));
      check({tag, "_state"}, 72'(State_s1), 72'(2'b00));
      check({tag, "_kernel"}, Kernel_s1, 72'(0));
      check({tag, "_window"}, Window_s1, 72'(0));
   endtask

   always @(negedge Phi1) begin
      if (Window_Valid_s1) begin
         n_strobe++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_strobe: got window %h expected no strobe", Window_s1);
         end else begin
            check($sformatf("window_%0d", n_strobe), Window_s1, exp_q.pop_front());
         end
      end
      if (State_s1 == 2'b01) check("ready_in_load", 72'(Input_Ready_s1), 72'(1));
   end

   always @(negedge Phi1) begin
      if (wv_s) begin
         n_strobe_s++;
         if (exp_qs.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL small_unexpected_strobe: got window %h expected no strobe", win_s);
         end else begin
            check($sformatf("small_window_%0d", n_strobe_s), win_s, exp_qs.pop_front());
         end
      end
   end

   // Small build: 9 kernel bytes, 8 priming zeros, 12-pixel ramp.
   initial begin
      rst_b_s = 1'b0;
      stall_s = 1'b0;
      pix_s   = 8'h00;
      for (int i = 0; i < 9; i++) srcs.push_back(8'(8'h10 + i));
      for (int i = 0; i < 8; i++) srcs.push_back(8'h00);
      for (int i = 0; i < 12; i++) srcs.push_back(8'(i));
      repeat (3) @(negedge Phi1);
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge Phi1);
         rst_b_s = 1'b1;
         if ((cyc == 0 || ready_s) && ptr_s < srcs.size()) begin
            pix_s = srcs[ptr_s];
            if (ptr_s == 16) check("small_last_prime_state", 72'(state_s), 72'(2'b10));
            if (ptr_s == 17) check("small_stream_entry", 72'(state_s), 72'(2'b11));
            if (ptr_s >= 17 && ((ptr_s - 17) % 4) >= 2) exp_qs.push_back(exp_win(ptr_s - 17, 4));
            ptr_s++;
         end else begin
            pix_s = 8'hEE;
         end
      end
      check("small_kernel", kern_s, 72'h101112131415161718);
      check("small_strobes", 72'(n_strobe_s), 72'(6));
      check("small_queue_empty", 72'(exp_qs.size()), 72'(0));
      check("small_done", 72'(done_s), 72'(1));
      small_done = 1'b1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_b_s1   = 1'b0;
      Out_Stall_s1 = 1'b0;
      Pixel_s1     = 8'h00;
      build_src(1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      reset_checks("rst");

      // Run 1: kernel, priming, full ramp without stall.
      load_kernel(72'h010203040506070809, "run1");
      run_to(IMG_BASE - 1);
      step(1'b1, 1'b0, 1'b0);
      check("last_prime_state", 72'(State_s1), 72'(2'b10));
      check("prime_no_strobe", 72'(n_strobe), 72'(0));
      step(1'b1, 1'b0, 1'b0);
      check("stream_entry", 72'(State_s1), 72'(2'b11));
      run_to(IMG_BASE + 90);
      check("done_before_last", 72'(Done_s1), 72'(0));
      step(1'b1, 1'b0, 1'b0);
      check("done_after_last", 72'(Done_s1), 72'(1));
      check("ready_in_done", 72'(Input_Ready_s1), 72'(0));
      repeat (4) step(1'b1, 1'b0, 1'b0);
      check("done_sticky", 72'(Done_s1), 72'(1));
      check("run1_strobes", 72'(n_strobe), 72'(72));
      check("run1_queue_empty", 72'(exp_q.size()), 72'(0));

      // Run 2: same image with a 5-cycle stall in the middle of row 2.
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      n_strobe = 0;
      build_src(1'b0);
      load_kernel(72'h010203040506070809, "run2");
      run_to(IMG_BASE + 25);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0);
         check($sformatf("stall_ready_%0d", i), 72'(Input_Ready_s1), 72'(0));
      end
      run_to(IMG_BASE + 90);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      check("run2_strobes", 72'(n_strobe), 72'(72));
      check("run2_queue_empty", 72'(exp_q.size()), 72'(0));
      check("run2_done", 72'(Done_s1), 72'(1));

      // Run 3: reset mid-stream, then reload an all-ones kernel.
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      build_src(1'b0);
      load_kernel(72'h010203040506070809, "run3");
      run_to(IMG_BASE + 40);
      step(1'b0, 1'b0, 1'b0);
      build_src(1'b1);
      step(1'b1, 1'b0, 1'b1);
      reset_checks("midrst");
      check("midrst_queue_empty", 72'(exp_q.size()), 72'(0));
      run_to(9);
      step(1'b1, 1'b0, 1'b0);
      check("ones_state_prime", 72'(State_s1), 72'(2'b10));
      check("ones_kernel", Kernel_s1, {72{1'b1}});

      for (int i = 0; i < 200 && !small_done; i++) @(negedge Phi1);
      if (!small_done) fail_now("small_build_finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pixel_receiver.md
Name: pixel_receiver

Overview:
Input front-end of the 2-D convolution engine. It is the consumer side of the pixel stream produced by the bench stimulus. It requests pixels with Input_Ready_s1 and captures Pixel_s1 into one of three places, in order:
- the 9-entry kernel register,
- the two line buffers (priming with zeros),
- the image stream, where it produces a 3x3 sliding window for the MAC array.

Parameters:
LINE_W, 10, pixels per image line (line-buffer depth); 3 or more.
NUM_ROWS, 9, image lines streamed; image size is LINE_W*NUM_ROWS (90).
NUM_KERNEL, 9, kernel coefficients; fixed at 9 for a 3x3 window.
PRIME_CNT, 2*LINE_W, zero pixels accepted after the kernel to fill the line buffers (localparam).

Ports:
Phi1  in  1  single system clock; all state updates on the rising edge.
Reset_b_s1  in  1  synchronous, active-low reset.
Pixel_s1  in  8  pixel/kernel byte from the stimulus.
Out_Stall_s1  in  1  downstream back-pressure; suppresses new requests.
Input_Ready_s1  out  1  registered request for the next byte.
Kernel_s1  out  72  K8..K0; first byte captured sits at [71:64], last at [7:0].
Window_s1  out  72  W0 at [7:0] .. W8 at [71:64].
Window_Valid_s1  out  1  one-cycle strobe; Window_s1 is valid this cycle.
State_s1  out  2  current state, for debug.
Done_s1  out  1  high once the full image has been consumed.

Behaviour:
- Synchronous reset (Reset_b_s1=0 at a Phi1 edge) returns the block to RESET from any state, including mid-stream. Reset values:
  - Input_Ready_s1=0, Window_Valid_s1=0, Done_s1=0, State_s1=RESET.
  - Kernel_s1, Window_s1, line buffers and all counters = 0.
- State encoding: RESET=00, LOAD_KERNEL=01, PRIME=10, STREAM=11. DONE is a sub-state of STREAM, flagged by Done_s1.
- Implicit first capture:
  - On the first edge with Reset_b_s1=1, the block captures Pixel_s1 unconditionally as byte 0 of the kernel and moves to LOAD_KERNEL.
  - No request precedes this byte.
- Capture rule:
  - The block captures Pixel_s1 on edge N+1 if and only if Input_Ready_s1 was 1 during cycle N.
  - Request-to-data latency is exactly one cycle.
  - A request, once issued, always completes, even if Out_Stall_s1 rises in between.
- Request generation:
  - Input_Ready_s1 is registered.
  - It is 1 in LOAD_KERNEL and PRIME every cycle.
  - In STREAM it is 1 when Out_Stall_s1=0 and outstanding+captured < LINE_W*NUM_ROWS.
  - It is 0 in RESET and in DONE.
- LOAD_KERNEL:
  - Captures shift into Kernel_s1 from the top: after 9 captures the first byte is at [71:64].
  - After the 9th capture, go to PRIME; the capture counter clears.
- PRIME:
  - Each capture is pushed through the line buffers (value not otherwise used).
  - After PRIME_CNT captures, go to STREAM.
  - Column and row counters clear on entry.
- STREAM window and line-buffer update, on each capture p:
  - The window shifts: W2<=W1, W1<=W0, W0<=p. Same for W5..W3 from line buffer 1 and W8..W6 from line buffer 2.
  - W3 <= line buffer 1 output and W6 <= line buffer 2 output, i.e. the pixel at the same column one and two rows earlier.
  - Line buffer 1 <= p; line buffer 2 <= line buffer 1 output. Both are LINE_W-deep FIFOs that advance only on a capture.
- STREAM column and row counters:
  - The column counter wraps at LINE_W-1.
  - The row counter increments on the wrap.
  - The window is not cleared at row wrap; edge windows are simply not flagged valid.
- Window_Valid_s1 is asserted the cycle after a STREAM capture whose column is 2 or more. This gives (LINE_W-2)*NUM_ROWS strobes per image (72 with defaults).
- Window_s1 and Kernel_s1 hold between strobes.
- When the capture counter reaches LINE_W*NUM_ROWS, Done_s1 rises the next cycle and stays high until reset. Further Pixel_s1 activity is ignored.
- Width rules: the capture counter is wide enough for max(PRIME_CNT, LINE_W*NUM_ROWS); all pixel data is 8-bit, with no arithmetic.

Test Plan:
- Reset, then kernel bytes 0x01..0x09 -> Kernel_s1 = 0x010203040506070809 after the 9th capture; State_s1 = 10; Input_Ready_s1 never low in LOAD_KERNEL.
- Priming: 20 zero pixels -> no Window_Valid_s1; State_s1 = 11 after the 20th capture.
- Stream a ramp 0..89, no stall:
  - First strobe: W0=2, W1=1, W2=0, W3..W8=0.
  - At row 2, col 2: W0=22, W3=12, W6=2, W8=0.
  - Exactly 72 strobes; Done_s1 rises one cycle after pixel 89.
- Out_Stall_s1 high for 5 cycles mid-row:
  - Input_Ready_s1 drops the next cycle.
  - The outstanding byte is still captured; no pixel is lost or duplicated.
  - Windows are identical to the no-stall run.
- Reset_b_s1=0 for 1 cycle at stream pixel 40:
  - All outputs return to reset values the next cycle.
  - A new kernel load of 0xFF x9 yields Kernel_s1 = all ones.
- LINE_W=4, NUM_ROWS=3 build with ramp input -> 6 strobes; PRIME_CNT = 8 captures.
